// File: rtl/kd_tree_ctrl_pkg.sv
// Shared sizes and state encoding for the k-d tree cluster controller.
// Also provides the depth helper that maps a zero depth setting to one level.
package kd_tree_ctrl_pkg;
  localparam int DIM         = 3;
  localparam int DATA_RANGE  = 255;
  localparam int MAX_DEPTH   = 16;
  localparam int DIM_SIZE    = $clog2(DATA_RANGE);
  localparam int DEPTH_SIZE  = $clog2(MAX_DEPTH);
  localparam int CENTER_SIZE = DIM * DIM_SIZE;
  // Holds 2*depth-1 for the longest SORT phase.
  localparam int STEP_SIZE   = DEPTH_SIZE + 1;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_ITER, S_WAIT_PT, S_RECV, S_DESCEND,
    S_ACC, S_UPDATE, S_SORT, S_CHECK, S_DONE
  } kd_state_e;

  function automatic logic [DEPTH_SIZE-1:0] eff_depth(input logic [DEPTH_SIZE-1:0] d);
    return (d == '0) ? DEPTH_SIZE'(1) : d;
  endfunction
endpackage

// File: rtl/kd_tree_ctrl_step_counter.sv
// Loadable down-counter with a zero flag.
// It times the DESCEND and SORT phases of the controller.
module kd_step_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/kd_tree_ctrl.sv
// Initiator for the cluster PE tree: streams points into the root PE and
// sequences k-means iterations until the tree reports stable or the cap is hit.
module kd_tree_ctrl
  import kd_tree_ctrl_pkg::*;
#(
  parameter int NUM_POINTS = 64,
  parameter int MAX_ITER   = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [DEPTH_SIZE-1:0]          depth_cfg,
  input  logic [CENTER_SIZE-1:0]         init_center,
  input  logic                           pt_valid,
  input  logic [CENTER_SIZE-1:0]         pt_data,
  output logic                           pt_ready,
  input  logic                           stable,
  input  logic                           switch_en,
  output logic                           en,
  output logic                           init,
  output logic                           start_iter,
  output logic                           receive_point,
  output logic                           next_level,
  output logic                           inc,
  output logic                           update,
  output logic                           sorting,
  output logic                           parent_switch,
  output logic                           child_switch,
  output logic [CENTER_SIZE-1:0]         parent_out,
  output logic [DEPTH_SIZE-1:0]          depth_out,
  output logic [CENTER_SIZE-1:0]         point_out,
  output logic [$clog2(MAX_ITER+1)-1:0]  iter_cnt,
  output logic                           busy,
  output logic                           done
);
  localparam int PCNT_SIZE = $clog2(NUM_POINTS + 1);
  localparam int ITER_SIZE = $clog2(MAX_ITER + 1);
  localparam logic [PCNT_SIZE-1:0] NP = PCNT_SIZE'(NUM_POINTS);
  localparam logic [ITER_SIZE-1:0] MI = ITER_SIZE'(MAX_ITER);

  kd_state_e state, state_d;
  logic [DEPTH_SIZE-1:0]  dep_q;
  logic [PCNT_SIZE-1:0]   pcnt;
  logic                   step_load, step_dec, step_zero;
  logic [STEP_SIZE-1:0]   step_val;
  logic                   sort_odd, sort_odd_d;
  logic                   run_d, init_d, iter_d, ready_d, recv_d, level_d, inc_d, upd_d, sort_d, done_d;
  logic [CENTER_SIZE-1:0] parent_d;
  logic [DEPTH_SIZE-1:0]  depth_d;
  logic                   start_ok, accept;

  assign start_ok = (state == S_IDLE || state == S_DONE) && start;
  assign accept   = (state == S_WAIT_PT) && pt_valid;

  kd_step_counter #(.W(STEP_SIZE)) u_step (
    .clk      (clk),
    .rst      (rst),
    .load     (step_load),
    .dec      (step_dec),
    .load_val (step_val),
    .zero     (step_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) state_d = S_INIT;
      S_INIT:         state_d = S_ITER;
      S_ITER:         state_d = S_WAIT_PT;
      S_WAIT_PT:      if (pt_valid) state_d = S_RECV;
      S_RECV:         state_d = (dep_q == DEPTH_SIZE'(1)) ? S_ACC : S_DESCEND;
      S_DESCEND:      if (step_zero) state_d = S_ACC;
      S_ACC:          state_d = (pcnt == NP) ? S_UPDATE : S_WAIT_PT;
      S_UPDATE:       state_d = S_SORT;
      S_SORT:         if (step_zero) state_d = S_CHECK;
      S_CHECK:        state_d = (stable || (iter_cnt + 1'b1 >= MI)) ? S_DONE : S_ITER;
      default:        state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up with the state.
  always_comb begin
    step_load = 1'b0;
    step_dec  = 1'b0;
    step_val  = '0;
    if (state == S_RECV) begin
      step_load = 1'b1;
      step_val  = {1'b0, dep_q} - STEP_SIZE'(2);
    end else if (state == S_UPDATE) begin
      step_load = 1'b1;
      step_val  = {dep_q, 1'b0} - STEP_SIZE'(1);
    end else if (state == S_DESCEND || state == S_SORT) begin
      step_dec  = 1'b1;
    end
    run_d      = !(state_d == S_IDLE || state_d == S_DONE);
    init_d     = (state_d == S_INIT);
    iter_d     = (state_d == S_ITER);
    ready_d    = (state_d == S_WAIT_PT);
    recv_d     = (state_d == S_RECV);
    level_d    = (state_d == S_RECV) || (state_d == S_DESCEND);
    inc_d      = (state_d == S_ACC);
    upd_d      = (state_d == S_UPDATE);
    sort_d     = (state_d == S_SORT);
    done_d     = (state_d == S_DONE);
    sort_odd_d = (state_d == S_SORT) && (state == S_SORT) && !sort_odd;
    parent_d   = init_d ? init_center : '0;
    depth_d    = init_d ? eff_depth(depth_cfg) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {en, busy, init, start_iter, pt_ready, receive_point} <= '0;
      {next_level, inc, update, sorting, sort_odd, done}    <= '0;
      parent_out <= '0;
      depth_out  <= '0;
    end else begin
      en            <= run_d;
      busy          <= run_d;
      init          <= init_d;
      start_iter    <= iter_d;
      pt_ready      <= ready_d;
      receive_point <= recv_d;
      next_level    <= level_d;
      inc           <= inc_d;
      update        <= upd_d;
      sorting       <= sort_d;
      sort_odd      <= sort_odd_d;
      done          <= done_d;
      parent_out    <= parent_d;
      depth_out     <= depth_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dep_q     <= '0;
      pcnt      <= '0;
      iter_cnt  <= '0;
      point_out <= '0;
    end else begin
      if (start_ok) begin
        dep_q    <= eff_depth(depth_cfg);
        iter_cnt <= '0;
        pcnt     <= '0;
      end
      if (state == S_ITER) pcnt <= '0;
      if (accept) begin
        point_out <= pt_data;
        if (pcnt != NP) pcnt <= pcnt + 1'b1;
      end
      if (state == S_CHECK && iter_cnt != MI) iter_cnt <= iter_cnt + 1'b1;
    end
  end

  // The PE decides the swap in the cycle it is offered, so switch_en gates the phase directly.
  assign parent_switch = sorting && !sort_odd && switch_en;
  assign child_switch  = sorting &&  sort_odd && switch_en;
endmodule
